// File: rtl/clk_div_ctrl.sv
// Glitch-safe sequencer for the system clock divider's div_sel/div_en controls.
// Optional power-manager requester port enabled by macro CLK_DIV_CTRL_PM_REQ_EN.
module clk_div_ctrl #(
  parameter int unsigned SETTLE_CYC = 32
) (
  input  logic       clki,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [1:0] req0_sel,
  input  logic       req0_en,
  output logic       req0_ack,
`ifdef CLK_DIV_CTRL_PM_REQ_EN
  input  logic       req1_valid,
  input  logic [1:0] req1_sel,
  input  logic       req1_en,
  output logic       req1_ack,
`endif
  output logic [1:0] div_sel,
  output logic       div_en,
  output logic       busy
);

  localparam logic [7:0] SettleLoad = 8'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    StIdle,
    StBypass,
    StSwitch,
    StEnable,
    StDone
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] tgt_sel_q, tgt_sel_d;
  logic       tgt_en_q, tgt_en_d;
  logic       gnt_id_q, gnt_id_d;
  logic [1:0] div_sel_q, div_sel_d;
  logic       div_en_q, div_en_d;
  logic       ack0_q, ack0_d;
`ifdef CLK_DIV_CTRL_PM_REQ_EN
  logic       ack1_q, ack1_d;
`endif

  logic       gnt;
  logic [1:0] gnt_sel;
  logic       gnt_en;
  logic       gnt_id;
  logic       cnt_zero;

  // Requester 1 (power manager) wins over requester 0 when both are valid.
  always_comb begin
`ifdef CLK_DIV_CTRL_PM_REQ_EN
    gnt = req1_valid | req0_valid;
    if (req1_valid) begin
      gnt_sel = req1_sel;
      gnt_en  = req1_en;
      gnt_id  = 1'b1;
    end else begin
      gnt_sel = req0_sel;
      gnt_en  = req0_en;
      gnt_id  = 1'b0;
    end
`else
    gnt     = req0_valid;
    gnt_sel = req0_sel;
    gnt_en  = req0_en;
    gnt_id  = 1'b0;
`endif
  end

  assign cnt_zero = (cnt_q == 8'd0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tgt_sel_d = tgt_sel_q;
    tgt_en_d  = tgt_en_q;
    gnt_id_d  = gnt_id_q;
    div_sel_d = div_sel_q;
    div_en_d  = div_en_q;

    unique case (state_q)
      StIdle: begin
        if (gnt) begin
          tgt_sel_d = gnt_sel;
          tgt_en_d  = gnt_en;
          gnt_id_d  = gnt_id;
          cnt_d     = SettleLoad;
          if ((gnt_sel == div_sel_q) && (gnt_en == div_en_q)) begin
            state_d = StDone;
          end else if (gnt_sel != div_sel_q) begin
            // Never move the select while the divider is running.
            if (div_en_q) begin
              state_d  = StBypass;
              div_en_d = 1'b0;
            end else begin
              state_d   = StSwitch;
              div_sel_d = gnt_sel;
            end
          end else begin
            state_d  = StEnable;
            div_en_d = gnt_en;
          end
        end
      end
      StBypass: begin
        if (cnt_zero) begin
          state_d   = StSwitch;
          div_sel_d = tgt_sel_q;
          cnt_d     = SettleLoad;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StSwitch: begin
        if (cnt_zero) begin
          if (tgt_en_q) begin
            state_d  = StEnable;
            div_en_d = 1'b1;
            cnt_d    = SettleLoad;
          end else begin
            state_d = StDone;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StEnable: begin
        if (cnt_zero) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    ack0_d = (state_d == StDone) && (state_q != StDone) && !gnt_id_d;
`ifdef CLK_DIV_CTRL_PM_REQ_EN
    ack1_d = (state_d == StDone) && (state_q != StDone) && gnt_id_d;
`endif
  end

  always_ff @(posedge clki) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= 8'd0;
      tgt_sel_q <= 2'b00;
      tgt_en_q  <= 1'b0;
      gnt_id_q  <= 1'b0;
      div_sel_q <= 2'b00;
      div_en_q  <= 1'b0;
      ack0_q    <= 1'b0;
`ifdef CLK_DIV_CTRL_PM_REQ_EN
      ack1_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tgt_sel_q <= tgt_sel_d;
      tgt_en_q  <= tgt_en_d;
      gnt_id_q  <= gnt_id_d;
      div_sel_q <= div_sel_d;
      div_en_q  <= div_en_d;
      ack0_q    <= ack0_d;
`ifdef CLK_DIV_CTRL_PM_REQ_EN
      ack1_q    <= ack1_d;
`endif
    end
  end

  assign div_sel  = div_sel_q;
  assign div_en   = div_en_q;
  assign busy     = (state_q != StIdle);
  assign req0_ack = ack0_q;
`ifdef CLK_DIV_CTRL_PM_REQ_EN
  assign req1_ack = ack1_q;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed self-checking bench for clk_div_ctrl with SETTLE_CYC = 4.
// Exercises the req1 arbitration path only when CLK_DIV_CTRL_PM_REQ_EN is defined.
module tb_clk_div_ctrl;

  logic       clki;
  logic       rst;
  logic       req0_valid;
  logic [1:0] req0_sel;
  logic       req0_en;
  logic       req0_ack;
`ifdef CLK_DIV_CTRL_PM_REQ_EN
  logic       req1_valid;
  logic [1:0] req1_sel;
  logic       req1_en;
  logic       req1_ack;
`endif
  logic [1:0] div_sel;
  logic       div_en;
  logic       busy;

  int checks;
  int failures;

  clk_div_ctrl #(
    .SETTLE_CYC(4)
  ) dut (
    .clki      (clki),
    .rst       (rst),
    .req0_valid(req0_valid),
    .req0_sel  (req0_sel),
    .req0_en   (req0_en),
    .req0_ack  (req0_ack),
`ifdef CLK_DIV_CTRL_PM_REQ_EN
    .req1_valid(req1_valid),
    .req1_sel  (req1_sel),
    .req1_en   (req1_en),
    .req1_ack  (req1_ack),
`endif
    .div_sel   (div_sel),
    .div_en    (div_en),
    .busy      (busy)
  );

  initial begin
    clki = 1'b0;
    forever #5 clki = ~clki;
  end

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clki);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a req0 change to completion (bounded), then return to IDLE with valid low.
  task automatic run_req0(input logic [1:0] sel, input logic en);
    bit got;
    got        = 1'b0;
    req0_sel   = sel;
    req0_en    = en;
    req0_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (req0_ack === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    check("setup_ack", {7'd0, got}, 8'd1);
    req0_valid = 1'b0;
    step();
    check("setup_sel", {6'd0, div_sel}, {6'd0, sel});
    check("setup_en", {7'd0, div_en}, {7'd0, en});
  endtask

  initial begin
    bit pm;
    logic [1:0] e_sel;
    logic e_en, e_ack0;
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    req0_valid = 1'b0;
    req0_sel   = 2'd0;
    req0_en    = 1'b0;
`ifdef CLK_DIV_CTRL_PM_REQ_EN
    pm         = 1'b1;
    req1_valid = 1'b0;
    req1_sel   = 2'd0;
    req1_en    = 1'b0;
`else
    pm         = 1'b0;
`endif
    step();
    step();
    rst = 1'b0;

    // Reset, then idle.
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("idle_busy_%0d", i), {7'd0, busy}, 8'd0);
      check($sformatf("idle_ack_%0d", i), {7'd0, req0_ack}, 8'd0);
    end
    check("rst_sel", {6'd0, div_sel}, 8'd0);
    check("rst_en", {7'd0, div_en}, 8'd0);

    run_req0(2'd0, 1'b1);

    // Full sequence (0,1) -> (3,1).
    req0_sel   = 2'd3;
    req0_en    = 1'b1;
    req0_valid = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      check($sformatf("full_en_T%0d", k), {7'd0, div_en}, {7'd0, !(k < 9)});
      check($sformatf("full_sel_T%0d", k), {6'd0, div_sel}, (k >= 5) ? 8'd3 : 8'd0);
      check($sformatf("full_ack_T%0d", k), {7'd0, req0_ack}, {7'd0, k == 13});
      check($sformatf("full_busy_T%0d", k), {7'd0, busy}, {7'd0, k <= 13});
      if (k == 13) req0_valid = 1'b0;
    end

    // No-change request.
    req0_valid = 1'b1;
    step();
    check("nochg_ack", {7'd0, req0_ack}, 8'd1);
    check("nochg_busy", {7'd0, busy}, 8'd1);
    check("nochg_sel", {6'd0, div_sel}, 8'd3);
    check("nochg_en", {7'd0, div_en}, 8'd1);
    req0_valid = 1'b0;
    step();
    check("nochg_busy_after", {7'd0, busy}, 8'd0);
    check("nochg_ack_after", {7'd0, req0_ack}, 8'd0);

    run_req0(2'd0, 1'b1);

    // Two back-to-back changes: req1 (2,0) wins over req0 (1,1) with PM, else req0 does both.
    req0_valid = 1'b1;
`ifdef CLK_DIV_CTRL_PM_REQ_EN
    req0_sel   = 2'd1;
    req0_en    = 1'b1;
    req1_sel   = 2'd2;
    req1_en    = 1'b0;
    req1_valid = 1'b1;
`else
    req0_sel   = 2'd2;
    req0_en    = 1'b0;
`endif
    for (int k = 1; k <= 20; k++) begin
      step();
      e_sel  = (k < 5) ? 2'd0 : (k <= 10) ? 2'd2 : 2'd1;
      e_en   = (k >= 15);
      e_ack0 = (k == 19) || (!pm && k == 9);
      check($sformatf("arb_sel_T%0d", k), {6'd0, div_sel}, {6'd0, e_sel});
      check($sformatf("arb_en_T%0d", k), {7'd0, div_en}, {7'd0, e_en});
      check($sformatf("arb_ack0_T%0d", k), {7'd0, req0_ack}, {7'd0, e_ack0});
`ifdef CLK_DIV_CTRL_PM_REQ_EN
      check($sformatf("arb_ack1_T%0d", k), {7'd0, req1_ack}, {7'd0, k == 9});
      if (k == 9) req1_valid = 1'b0;
`else
      if (k == 9) begin
        req0_sel = 2'd1;
        req0_en  = 1'b1;
      end
`endif
      if (k == 19) req0_valid = 1'b0;
    end

    // Reset in the middle of a full sequence (1,1) -> (3,1).
    req0_sel   = 2'd3;
    req0_en    = 1'b1;
    req0_valid = 1'b1;
    for (int k = 1; k <= 6; k++) step();
    check("mid_sel_before", {6'd0, div_sel}, 8'd3);
    rst = 1'b1;
    step();
    rst        = 1'b0;
    req0_valid = 1'b0;
    check("mid_sel", {6'd0, div_sel}, 8'd0);
    check("mid_en", {7'd0, div_en}, 8'd0);
    check("mid_busy", {7'd0, busy}, 8'd0);
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("mid_noack_%0d", i), {7'd0, req0_ack}, 8'd0);
    end

    // Payload change after grant is ignored; dropping valid still completes.
    req0_sel   = 2'd2;
    req0_en    = 1'b1;
    req0_valid = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      check($sformatf("pay_sel_T%0d", k), {6'd0, div_sel}, 8'd2);
      check($sformatf("pay_en_T%0d", k), {7'd0, div_en}, {7'd0, k >= 5});
      check($sformatf("pay_ack_T%0d", k), {7'd0, req0_ack}, {7'd0, k == 9});
      if (k == 2) begin
        req0_sel = 2'd1;
        req0_en  = 1'b0;
      end
      if (k == 3) req0_valid = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Sequencer that owns the `div_sel`/`div_en` controls of the system clock divider and changes them glitch-safely. It accepts divider-change requests from software (requester 0) and from the low-power manager (requester 1), arbitrates between them, and walks each change through bypass → select → enable. Each step is held for a settle interval so the downstream clock muxes finish their internal handover before the next control edge. It sits in `clk_rst_sys`, clocked from the undivided source clock, directly driving the divider's select and enable inputs.

## Interface
- `SETTLE_CYC`, 32, `clki` cycles held in each wait state; legal 1..255. 32 covers two periods of the ÷16 clock.
- `clki`  in  1  source clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid`  in  1  software change request; held until `req0_ack`.
- `req0_sel`  in  2  requested divide select (0=÷2, 1=÷4, 2=÷8, 3=÷16).
- `req0_en`  in  1  requested divider enable (0 = bypass, undivided clock).
- `req0_ack`  out  1  one-cycle completion pulse for requester 0.
- `req1_valid`, `req1_sel[1:0]`, `req1_en`, `req1_ack`: same semantics for the power manager. Present only with `CLK_DIV_CTRL_PM_REQ_EN`.
- `div_sel`  out  2  registered divide select to the divider.
- `div_en`  out  1  registered divider enable to the divider.
- `busy`  out  1  high while a sequence is in progress (not IDLE).

## Operation
- Reset values: `div_sel`=2'b00, `div_en`=0, `busy`=0, both acks 0, state=IDLE.
- States: IDLE, BYPASS, SWITCH, ENABLE, DONE. Settle counter is 8 bits; it loads `SETTLE_CYC-1` on entry to each wait state and the state exits when the counter reads 0.
- Grant happens only in IDLE. Fixed priority: req1 over req0. The granted requester's sel/en are captured into target registers, along with a grant-ID bit.
- Transitions out of IDLE on grant:
  - target equals current (`sel`==`div_sel` and `en`==`div_en`) → DONE.
  - sel differs and `div_en`=1 → BYPASS.
  - sel differs and `div_en`=0 → SWITCH.
  - sel equal, en differs → ENABLE.
- BYPASS: `div_en`=0. After settle → SWITCH.
- SWITCH: `div_sel`=target sel. After settle → ENABLE if target en=1, else DONE.
- ENABLE: `div_en`=target en. After settle → DONE.
- DONE: pulse ack of the granted requester for exactly one cycle, then → IDLE.
- `div_en` and `div_sel` never change in the same cycle; at most one control edge per settle interval.
- Handshake:
  - Valid must be held until ack.
  - Payload changes after grant are ignored.
  - Valid dropped before grant = withdrawn, no ack.
  - Valid dropped after grant: the sequence still completes and ack still pulses.
  - Valid still high in the cycle after ack is treated as a new request.
- Requests arriving while busy wait; there is no queueing beyond the held valid.
- Reset mid-sequence: all outputs return to reset values on the next edge, no ack is issued, and the pending grant is discarded.

## Timing
- Let T be the IDLE cycle in which valid is sampled (the grant edge). Let S = `SETTLE_CYC`.
- Full sequence (en 1→1, sel change):
  - BYPASS over T+1..T+S, with `div_en`=0 visible from T+1.
  - SWITCH from T+S+1, with the new `div_sel`.
  - ENABLE from T+2S+1, with `div_en`=1.
  - DONE at T+3S+1, ack high that cycle.
  - IDLE at T+3S+2; earliest next grant is that cycle.
- No-change request: DONE at T+1, ack at T+1.
- `busy`=1 from T+1 through the DONE cycle inclusive.
- Simultaneous req0/req1 valid at T: req1 is granted. req0 is granted at the first IDLE cycle after req1's DONE if it is still valid.

## Configuration
- `CLK_DIV_CTRL_PM_REQ_EN` defined: the req1 ports exist and priority arbitration applies.
- Not defined: the req1 ports are absent, req0 is the only requester, and the grant logic reduces to `req0_valid` in IDLE. All timing is otherwise identical.

## Test plan
All scenarios use S=4.
- Reset, then idle 10 cycles → `div_sel`=0, `div_en`=0, `busy`=0, no ack.
- From (sel 0, en 1), req0 asks (sel 3, en 1) at T → `div_en`=0 at T+1; `div_sel`=3 at T+5; `div_en`=1 at T+9; `req0_ack` pulses at T+13 only.
- From (sel 3, en 1), req0 asks (sel 3, en 1) → `req0_ack` at T+1, no output change, `busy` high for 1 cycle.
- req0 (sel 1, en 1) and req1 (sel 2, en 0) both valid at T from (sel 0, en 1) → req1 sequence ends with `div_sel`=2, `div_en`=0, `req1_ack` at T+9. req0 is then granted at T+10; starting from `div_en`=0 it skips BYPASS, giving `div_sel`=1 at T+11 and `div_en`=1 at T+15.
- `rst` asserted at T+6 of a full sequence → `div_sel`=0, `div_en`=0, `busy`=0 at T+7; no ack ever issued for that request.
- req0 changes its payload at T+2 and drops valid at T+3 → the original captured target is applied and `req0_ack` still pulses at completion.
